uart_ovs_rx: RTL and testbench
==============================

UART_OVS_RX -- requirements
Module: uart_ovs_rx

Interface
REQ-001 SHALL have parameter system_clk, default 50_000000, system clock frequency in Hz.
REQ-002 SHALL have parameter band_rate, default 9600, line baud rate.
REQ-003 SHALL have parameter data_bits, default 8, data bits per frame, legal range 5-8.
REQ-004 SHALL have parameter check_mode, default 1: 0 none, 1 even, 2 odd, 3 fixed 0, 4 fixed 1.
REQ-005 SHALL have port clk  input  1  system clock; the block uses this one clock only.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rx_en  input  1  receiver enable, active high.
REQ-008 SHALL have port rx  input  1  asynchronous UART line, idle high.
REQ-009 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-010 SHALL have port m_axis_tdata  output  8  received byte, LSB-aligned; unused upper bits are 0.
REQ-011 SHALL have port m_axis_tvalid  output  1  byte valid.
REQ-012 SHALL have port check_flag  output  1  parity error for the held byte; meaningful only while tvalid=1.
REQ-013 SHALL have port frame_err  output  1  stop bit sampled 0 for the held byte; meaningful only while tvalid=1.
REQ-014 SHALL have port break_flag  output  1  one-clk pulse on line break detection.
REQ-015 SHALL have port overrun  output  1  one-clk pulse when a completed byte is dropped.

Function
REQ-016 SHALL pass rx through a 2-FF synchronizer before any use; this adds 2 clk of input latency.
REQ-017 SHALL generate a 16x oversample tick: a one-clk pulse every DIV = round(system_clk/(band_rate*16)) clocks, from a free-running counter that wraps at DIV-1.
REQ-018 SHALL implement FSM states IDLE, START, DATA, CHECK, STOP, BREAK.
REQ-019 SHALL move IDLE->START on a synchronized falling edge of rx, and restart the oversample phase counter at that edge.
REQ-020 SHALL take each bit value as the majority of oversamples 7, 8 and 9 of the 16 in that bit.
REQ-021 SHALL return START->IDLE without output if the start-bit majority is 1 (glitch rejection); otherwise move to DATA.
REQ-022 SHALL shift DATA bits in LSB first and count data_bits bits.
REQ-023 SHALL move DATA->CHECK when check_mode != 0, else DATA->STOP.
REQ-024 SHALL set check_flag in CHECK as follows: even mode, XOR of data and parity bit = 1; odd mode, XOR = 0; mode 3, parity bit = 1; mode 4, parity bit = 0.
REQ-025 SHALL set check_flag to 0 when check_mode = 0.
REQ-026 SHALL, in STOP, take the stop-bit majority, then leave STOP immediately without waiting for the stop-bit end.
REQ-027 SHALL treat a STOP sample of 0 with all data bits, the parity bit (if present) and the stop bit all 0 as a break: pulse break_flag, deliver no byte, go to BREAK.
REQ-028 SHALL leave BREAK for IDLE only after synchronized rx reads 1.
REQ-029 SHALL, for any other STOP sample, complete the byte and return to IDLE; frame_err = NOT stop bit.
REQ-030 SHALL latch a completed byte into a single-entry output register and raise m_axis_tvalid 1 clk after the oversample-9 tick of the stop bit.
REQ-031 SHALL latch tdata, check_flag and frame_err together with tvalid.
REQ-032 SHALL hold tvalid, tdata, check_flag and frame_err stable until the clock edge where tvalid and tready are both 1; tvalid then clears.
REQ-033 SHALL never make tvalid depend combinationally on tready.
REQ-034 SHALL, when a byte completes in the same clk as the handshake, load the new byte and keep tvalid at 1.
REQ-035 SHALL, when a byte completes while tvalid=1 and tready=0, drop the new byte, keep the old byte and pulse overrun for 1 clk.
REQ-036 SHALL, when rx_en=0, force the FSM to IDLE at the next clk and discard any partial frame.
REQ-037 SHALL keep the output register and handshake operating while rx_en=0.

Reset
REQ-038 SHALL, on rst_n low, asynchronously set: FSM to IDLE; counters to 0; both synchronizer FFs to 1; m_axis_tdata to 0x00; m_axis_tvalid, check_flag, frame_err, break_flag and overrun to 0.
REQ-039 SHALL drop any frame in progress when reset is asserted; after release, reception starts only on a new falling edge.

Structure
REQ-040 SHALL take the following from the shared package uart_pkg: FSM state encoding, check_mode constants, and the DIV computation function.
REQ-041 SHALL instantiate the oversample tick generator as the sub-module ovs_tick_gen, with parameter DIV and a phase-restart input.

Verification
REQ-042 SHALL be verified with band_rate=115200 (DIV=27), 8 data bits, check_mode=1, tready=1, sending 0xA5 with parity bit 0 and stop bit 1. Required response: one beat with tdata=0xA5, check_flag=0, frame_err=0.
REQ-043 SHALL be verified by sending 0x01 with parity bit 0. Required response: tdata=0x01, check_flag=1.
REQ-044 SHALL be verified with an rx low pulse of 100 clk (<8 oversamples). Required response: no tvalid and FSM back in IDLE; a following 0x3C is received correctly.
REQ-045 SHALL be verified with rx held low for 12 bit times. Required response: one break_flag pulse and no tvalid; after rx returns high, 0x3C is received.
REQ-046 SHALL be verified with tready=0 while sending 0x11 and then 0x22. Required response: tdata stays 0x11, overrun pulses once; when tready=1, one handshake occurs and tvalid drops.
REQ-047 SHALL be verified with rx_en=0 asserted in mid-frame, then 1 again. Required response: no output for the aborted frame; the next frame, 0x5A, is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, check-mode codes,
// oversample positions and the baud divisor helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_BREAK = 3'd5;

  localparam int unsigned CHK_NONE = 0;
  localparam int unsigned CHK_EVEN = 1;
  localparam int unsigned CHK_ODD  = 2;
  localparam int unsigned CHK_ZERO = 3;
  localparam int unsigned CHK_ONE  = 4;

  // Tick counter value seen when the Nth oversample tick of a bit arrives is N-1.
  localparam logic [3:0] OVS_S7  = 4'd6;
  localparam logic [3:0] OVS_S8  = 4'd7;
  localparam logic [3:0] OVS_S9  = 4'd8;
  localparam logic [3:0] OVS_END = 4'd15;

  // Clocks per 16x oversample tick, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud * 8) / (baud * 16);
  endfunction

endpackage

// File: rtl/uart_ovs_rx_if.sv
// Byte-stream handshake bundle of the oversampling receiver, with its status sidebands.
interface uart_ovs_rx_if;

  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       check_flag;
  logic       frame_err;

  modport master (
    output m_axis_tdata,
    output m_axis_tvalid,
    output check_flag,
    output frame_err,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  check_flag,
    input  frame_err,
    output m_axis_tready
  );

endinterface

// File: rtl/ovs_tick_gen.sv
// Free-running 16x oversample tick generator; restart realigns the phase to a start edge.
module ovs_tick_gen #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign a default before any branch so no latch is
  // inferred; clocked blocks use only non-blocking assignments.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST) && !restart;

endmodule

// File: rtl/uart_ovs_rx.sv
// 16x oversampling UART receiver with majority voting, parity/frame/break detection
// and a single-entry valid/ready output register.
module uart_ovs_rx
  import uart_pkg::*;
#(
  parameter int unsigned system_clk = 50_000000,
  parameter int unsigned band_rate  = 9600,
  parameter int unsigned data_bits  = 8,
  parameter int unsigned check_mode = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_en,
  input  logic       rx,
  input  logic       m_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       check_flag,
  output logic       frame_err,
  output logic       break_flag,
  output logic       overrun
);

  localparam int unsigned DIV      = calc_div(system_clk, band_rate);
  localparam logic [2:0]  LAST_BIT = 3'(data_bits - 1);
  localparam int unsigned PAD      = 8 - data_bits;

  logic       sync1_q, sync2_q, rx_prev_q;
  logic       tick, restart, fall, maj;
  logic       at_s7, at_s8, at_s9, at_end;

  logic [2:0] state_q, state_d;
  logic [3:0] ovs_cnt_q, ovs_cnt_d;
  logic [1:0] smp_q, smp_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       ones_q, ones_d;

  logic       byte_done, brk_det, chk_new, hs;
  logic [7:0] data_new;

  logic [7:0] tdata_q, tdata_d;
  logic       tvalid_q, tvalid_d;
  logic       chk_q, chk_d;
  logic       ferr_q, ferr_d;
  logic       brk_q, brk_d;
  logic       ovr_q, ovr_d;

  // Line synchronizer plus one history stage for falling-edge detection; all idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  assign fall = rx_prev_q & ~sync2_q;

  ovs_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  assign at_s7  = tick && (ovs_cnt_q == OVS_S7);
  assign at_s8  = tick && (ovs_cnt_q == OVS_S8);
  assign at_s9  = tick && (ovs_cnt_q == OVS_S9);
  assign at_end = tick && (ovs_cnt_q == OVS_END);

  // Vote of oversamples 7 and 8 (held) with oversample 9 (live).
  assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);

  always_comb begin
    state_d   = state_q;
    ovs_cnt_d = tick ? ovs_cnt_q + 4'd1 : ovs_cnt_q;
    smp_d     = smp_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    ones_d    = ones_q;
    restart   = 1'b0;
    byte_done = 1'b0;
    brk_det   = 1'b0;

    if (at_s7) smp_d[0] = sync2_q;
    if (at_s8) smp_d[1] = sync2_q;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d   = ST_START;
          restart   = 1'b1;
          ovs_cnt_d = '0;
          bit_cnt_d = '0;
          shift_d   = '0;
          par_d     = 1'b0;
          ones_d    = 1'b0;
        end
      end
      ST_START: begin
        if (at_s9 && maj) state_d = ST_IDLE;
        else if (at_end)  state_d = ST_DATA;
      end
      ST_DATA: begin
        if (at_s9) begin
          shift_d = {maj, shift_q[7:1]};
          ones_d  = ones_q | maj;
        end
        if (at_end) begin
          if (bit_cnt_q == LAST_BIT) state_d = (check_mode != CHK_NONE) ? ST_CHECK : ST_STOP;
          else                       bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      ST_CHECK: begin
        if (at_s9) begin
          par_d  = maj;
          ones_d = ones_q | maj;
        end
        if (at_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Decide at the stop-bit centre so back-to-back start edges are not missed.
        if (at_s9) begin
          if (!maj && !ones_q) begin
            brk_det = 1'b1;
            state_d = ST_BREAK;
          end else begin
            byte_done = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        if (sync2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rx_en) begin
      state_d   = ST_IDLE;
      restart   = 1'b0;
      byte_done = 1'b0;
      brk_det   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ovs_cnt_q <= '0;
      smp_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      ones_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ovs_cnt_q <= ovs_cnt_d;
      smp_q     <= smp_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      ones_q    <= ones_d;
    end
  end

  // Stale low bits of the shifter are cleared at the start edge, so they do not disturb parity.
  assign data_new = shift_q >> PAD;

  always_comb begin
    case (check_mode)
      CHK_EVEN: chk_new = (^shift_q) ^ par_q;
      CHK_ODD:  chk_new = ~((^shift_q) ^ par_q);
      CHK_ZERO: chk_new = par_q;
      CHK_ONE:  chk_new = ~par_q;
      default:  chk_new = 1'b0;
    endcase
  end

  assign hs = tvalid_q & m_axis_tready;

  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    chk_d    = chk_q;
    ferr_d   = ferr_q;
    brk_d    = brk_det;
    ovr_d    = 1'b0;

    if (byte_done) begin
      if (!tvalid_q || hs) begin
        tdata_d  = data_new;
        tvalid_d = 1'b1;
        chk_d    = chk_new;
        ferr_d   = ~maj;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (hs) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      chk_q    <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      chk_q    <= chk_d;
      ferr_q   <= ferr_d;
      brk_q    <= brk_d;
      ovr_q    <= ovr_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign check_flag    = chk_q;
  assign frame_err     = ferr_q;
  assign break_flag    = brk_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_ovs_rx.sv
// Self-checking bench for uart_ovs_rx at 115200 baud / 50 MHz: directed and random
// frames scored against a frame-level model of the receiver's rules.
module tb_uart_ovs_rx;

  localparam int unsigned CLK_HZ   = 50_000_000;
  localparam int unsigned BAUD     = 115200;
  localparam int          BIT_CLKS = 16 * 27;
  localparam int          GAP_CLKS = BIT_CLKS / 2;

  typedef struct packed {
    logic [7:0] data;
    logic       chk;
    logic       ferr;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_en = 1'b0;
  logic rx    = 1'b1;
  logic break_flag, overrun;

  uart_ovs_rx_if axis();

  uart_ovs_rx #(
    .system_clk(CLK_HZ),
    .band_rate (BAUD),
    .data_bits (8),
    .check_mode(1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_en        (rx_en),
    .rx           (rx),
    .m_axis_tready(axis.m_axis_tready),
    .m_axis_tdata (axis.m_axis_tdata),
    .m_axis_tvalid(axis.m_axis_tvalid),
    .check_flag   (axis.check_flag),
    .frame_err    (axis.frame_err),
    .break_flag   (break_flag),
    .overrun      (overrun)
  );

  always #10 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    brk_cnt  = 0;
  int    ovr_cnt  = 0;
  int    exp_brk  = 0;
  int    exp_ovr  = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshakes and pulses are sampled on the falling edge, between active edges.
  always @(negedge clk) begin
    if (rst_n) begin
      if (axis.m_axis_tvalid && axis.m_axis_tready) begin
        beat_t b;
        b.data = axis.m_axis_tdata;
        b.chk  = axis.check_flag;
        b.ferr = axis.frame_err;
        obs_q.push_back(b);
      end
      if (break_flag) brk_cnt++;
      if (overrun)    ovr_cnt++;
    end
  end

  // Frame-level model: even parity over data plus parity bit, break when the whole
  // frame after the start bit reads zero.
  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
    beat_t b;
    if (!stop && d == 8'h00 && !par) begin
      exp_brk++;
    end else begin
      b.data = d;
      b.chk  = (($countones(d) + int'(par)) % 2) == 1;
      b.ferr = !stop;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(BIT_CLKS);
    end
    rx = par;
    wait_clks(BIT_CLKS);
    rx = stop;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
    wait_clks(GAP_CLKS);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic par, input logic stop);
    model_frame(d, par, stop);
    send_frame(d, par, stop);
  endtask

  task automatic compare_beats(input string tag);
    beat_t e, o;
    check({tag, "/beats"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "/tdata"},      o.data, e.data);
      check({tag, "/check_flag"}, o.chk,  e.chk);
      check({tag, "/frame_err"},  o.ferr, e.ferr);
    end
    exp_q.delete();
    obs_q.delete();
    check({tag, "/breaks"},   brk_cnt, exp_brk);
    check({tag, "/overruns"}, ovr_cnt, exp_ovr);
  endtask

  initial begin
    logic [7:0] d;
    logic       par, stop;

    axis.m_axis_tready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst/tvalid",     axis.m_axis_tvalid, 0);
    check("rst/tdata",      axis.m_axis_tdata,  0);
    check("rst/check_flag", axis.check_flag,    0);
    check("rst/frame_err",  axis.frame_err,     0);
    check("rst/break_flag", break_flag,         0);
    check("rst/overrun",    overrun,            0);

    wait_clks(1);
    rst_n = 1'b1;
    rx_en = 1'b1;
    wait_clks(20);

    expect_frame(8'hA5, 1'b0, 1'b1);
    compare_beats("a5");
    expect_frame(8'h01, 1'b0, 1'b1);
    compare_beats("parity_err");

    // Start-bit glitch shorter than seven oversamples.
    rx = 1'b0;
    wait_clks(100);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    compare_beats("glitch");
    expect_frame(8'h3C, 1'b0, 1'b1);
    compare_beats("after_glitch");

    // Line held low for twelve bit times.
    rx = 1'b0;
    wait_clks(12 * BIT_CLKS);
    exp_brk++;
    check("break/tvalid", axis.m_axis_tvalid, 0);
    rx = 1'b1;
    wait_clks(GAP_CLKS);
    compare_beats("break");
    expect_frame(8'h3C, 1'b0, 1'b1);
    compare_beats("after_break");

    for (int k = 0; k < 4; k++) begin
      d    = 8'($urandom_range(0, 255));
      par  = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      expect_frame(d, par, stop);
      wait_clks($urandom_range(0, 200));
    end
    compare_beats("random");

    // Second byte arrives while the first is still held.
    axis.m_axis_tready = 1'b0;
    model_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    exp_ovr++;
    check("ovr/tvalid_held", axis.m_axis_tvalid, 1);
    check("ovr/tdata_held",  axis.m_axis_tdata,  8'h11);
    check("ovr/pulses",      ovr_cnt,            exp_ovr);
    check("ovr/no_beat_yet", obs_q.size(),       0);
    axis.m_axis_tready = 1'b1;
    wait_clks(4);
    check("ovr/tvalid_drop", axis.m_axis_tvalid, 0);
    compare_beats("overrun");

    // Receiver disabled partway through a frame.
    d = 8'($urandom_range(0, 255));
    fork
      send_frame(d, 1'b1, 1'b1);
      begin
        wait_clks($urandom_range(600, 3500));
        rx_en = 1'b0;
      end
    join
    rx_en = 1'b1;
    wait_clks(20);
    compare_beats("abort");
    expect_frame(8'h5A, 1'b0, 1'b1);
    compare_beats("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
